// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the sequenced N-to-1 word multiplexer.
//   state_e     - sequencer states (IDLE: one word per input beat, SCAN: walking the buffer)
//   MODE_*      - values of the mode input sampled on input accept
//   idx_width() - channel-index width for a given channel count (never below 1 bit)
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_seq_nto1_if.sv
// mux_seq_nto1_if: input-beat and output-word handshakes of mux_seq_nto1.
//   in_data   N*W  channel k at bits [k*W +: W]
//   in_valid / in_ready    input beat, accepted when both are high
//   mode, sel              sampled only when an input beat is accepted
//   out_data / out_ch / out_last   registered output word, its channel, end-of-beat flag
//   out_valid / out_ready  output word, accepted when both are high
//   busy, dbg_state        sequencer observation (busy = state is SCAN)
//
// Handshake rule for both sides: a transfer happens on a rising clock edge where
// valid and ready are both high; the producer holds valid and its payload stable
// until that edge, and ready never depends on the valid of the same channel.
interface mux_seq_nto1_if
  import mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) ();

  localparam int SW = idx_width(N);

  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  state_e         dbg_state;

  // Environment side: drives the input beat and the downstream ready.
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid, busy, dbg_state
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid, busy, dbg_state
  );

endinterface

// File: rtl/mux_word_nto1.sv
// mux_word_nto1: combinational N-to-1 word select from a flat bus.
//   data_i  N*W  word k at bits [k*W +: W]
//   idx_i   SW   selected word index
//   word_o  W    selected word, or 0 when idx_i >= N
module mux_word_nto1
  import mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SW = idx_width(N)
) (
  input  logic [N*W-1:0] data_i,
  input  logic [SW-1:0]  idx_i,
  output logic [W-1:0]   word_o
);

  // Indices with no matching word fall through to the zero default.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx_i) == k) begin
        word_o = data_i[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_seq_nto1.sv
// mux_seq_nto1: registered N-to-1 word multiplexer with a channel sequencer.
//   clk  rising-edge clock
//   rst  synchronous active-high reset, wins over any handshake in the same cycle
//   bus  mux_seq_nto1_if.slave (input beat, output word, busy/debug state)
// Direct mode registers the selected channel once per accepted beat. Scan mode
// captures every channel and emits them in order 0..N-1, one per output handshake.
module mux_seq_nto1
  import mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux_seq_nto1_if.slave   bus
);

  localparam int SW = idx_width(N);
  // idx has to reach N after the final word is loaded, so it is one bit wider
  // than a channel index whenever N is a power of two.
  localparam int IW = idx_width(N + 1);
  localparam logic [IW-1:0] IDX_N    = IW'(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_d;
  logic [N*W-1:0] buf_q;
  logic [W-1:0]   data_q;
  logic [SW-1:0]  ch_q;
  logic           last_q;
  logic           valid_q;

  logic           in_ready;
  logic           in_fire;
  logic           out_fire;
  logic [W-1:0]   direct_word;
  logic [W-1:0]   scan_word;

  // Ready is held low while rst is asserted so no beat appears to be accepted
  // during reset; otherwise a new beat is taken only when the output register
  // is free or being emptied in the same cycle.
  assign in_ready = !rst && (state_q == IDLE) && (!valid_q || bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = valid_q && bus.out_ready;
  assign idx_d    = idx_q + IW'(1);

  mux_word_nto1 #(.N(N), .W(W)) u_direct (
    .data_i (bus.in_data),
    .idx_i  (bus.sel),
    .word_o (direct_word)
  );

  mux_word_nto1 #(.N(N), .W(W)) u_scan (
    .data_i (buf_q),
    .idx_i  (idx_q[SW-1:0]),
    .word_o (scan_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            if (bus.mode == MODE_SCAN) begin
              buf_q   <= bus.in_data;
              data_q  <= bus.in_data[W-1:0];
              ch_q    <= '0;
              last_q  <= (N == 1);
              valid_q <= 1'b1;
              idx_q   <= IW'(1);
              state_q <= SCAN;
            end else begin
              data_q  <= direct_word;
              ch_q    <= bus.sel;
              last_q  <= 1'b1;
              valid_q <= 1'b1;
            end
          end else if (out_fire) begin
            valid_q <= 1'b0;
          end
        end
        SCAN: begin
          if (out_fire) begin
            if (last_q) begin
              // Final word taken: leave SCAN; in_ready rises next cycle.
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else if (idx_q < IDX_N) begin
              data_q <= scan_word;
              ch_q   <= idx_q[SW-1:0];
              last_q <= (idx_q == IDX_LAST);
              idx_q  <= idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_seq_nto1.sv
// tb_mux_seq_nto1: bench for mux_seq_nto1 (N = 8 main instance, N = 5 for the
// out-of-range select case). A queue of words still owed downstream serves as
// the reference; directed sections pin it with literal values.
module tb_mux_seq_nto1;
  import mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int N5 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_seq_nto1_if #(.N(N),  .W(W)) b8 ();
  mux_seq_nto1_if #(.N(N5), .W(W)) b5 ();

  mux_seq_nto1 #(.N(N),  .W(W)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  mux_seq_nto1 #(.N(N5), .W(W)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  int total = 0;
  int bad   = 0;

  // Entry = {data, channel, last}
  logic [W+SW:0] exp_q[$];
  int scan_left = 0;
  bit model_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] base);
    for (int k = 0; k < N; k++) b8.in_data[k*W +: W] = 8'(base + 8'(k));
  endtask

  // ---------------- scoreboard / model ----------------
  // Words owed downstream sit in exp_q; the head is what out_* must show.
  // SCAN is exactly "scan words are still owed", so busy and in_ready follow.
  always @(negedge clk) begin : model
    logic [W+SW:0] head;
    bit ev;
    bit er;
    if (model_on) begin
      ev = (exp_q.size() != 0);
      er = !rst && (scan_left == 0) && (!ev || b8.out_ready);
      check("m_out_valid", 32'(b8.out_valid), 32'(ev));
      check("m_in_ready",  32'(b8.in_ready),  32'(er));
      check("m_busy",      32'(b8.busy),      32'(scan_left != 0));
      if (ev) begin
        head = exp_q[0];
        check("m_out_data", 32'(b8.out_data), 32'(head[W+SW:SW+1]));
        check("m_out_ch",   32'(b8.out_ch),   32'(head[SW:1]));
        check("m_out_last", 32'(b8.out_last), 32'(head[0]));
      end
      if (rst) begin
        exp_q.delete();
        scan_left = 0;
      end else begin
        if (ev && b8.out_ready) begin
          void'(exp_q.pop_front());
          if (scan_left > 0) scan_left--;
        end
        if (b8.in_valid && er) begin
          if (b8.mode) begin
            for (int k = 0; k < N; k++)
              exp_q.push_back({b8.in_data[k*W +: W], SW'(k), (k == N-1) ? 1'b1 : 1'b0});
            scan_left = N;
          end else begin
            exp_q.push_back({b8.in_data[int'(b8.sel)*W +: W], b8.sel, 1'b1});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    b8.in_data = '0; b8.in_valid = 1'b1; b8.mode = 1'b0; b8.sel = '0; b8.out_ready = 1'b0;
    b5.in_data = '0; b5.in_valid = 1'b0; b5.mode = 1'b0; b5.sel = '0; b5.out_ready = 1'b1;

    // Reset held 2 cycles with in_valid high.
    tick();
    model_on = 1'b1;
    for (int r = 0; r < 2; r++) begin
      check("rst_out_data",  32'(b8.out_data),  32'(0));
      check("rst_out_ch",    32'(b8.out_ch),    32'(0));
      check("rst_out_last",  32'(b8.out_last),  32'(0));
      check("rst_out_valid", 32'(b8.out_valid), 32'(0));
      check("rst_busy",      32'(b8.busy),      32'(0));
      check("rst_in_ready",  32'(b8.in_ready),  32'(0));
      if (r == 0) tick();
    end
    rst = 1'b0;
    b8.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(b8.in_ready), 32'(1));

    // Direct stream: sel 3, 5, 7 back to back.
    tick();
    load8(8'h10);
    b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.mode = MODE_DIRECT;
    b8.sel = 3'd3; tick();
    check("dir0_data", 32'(b8.out_data), 32'h13);
    check("dir0_last", 32'(b8.out_last), 32'(1));
    b8.sel = 3'd5; tick();
    check("dir1_data", 32'(b8.out_data), 32'h15);
    check("dir1_valid", 32'(b8.out_valid), 32'(1));
    b8.sel = 3'd7; tick();
    check("dir2_data", 32'(b8.out_data), 32'h17);
    check("dir2_ch",   32'(b8.out_ch),   32'(7));
    b8.in_valid = 1'b0; tick();
    check("dir_drained", 32'(b8.out_valid), 32'(0));

    // Scan with a 3-cycle stall on channel 2; mode/sel toggled mid-scan.
    load8(8'hA0);
    b8.mode = MODE_SCAN; b8.in_valid = 1'b1; tick();
    b8.in_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      check("scan_data", 32'(b8.out_data), 32'(8'hA0 + j));
      check("scan_ch",   32'(b8.out_ch),   32'(j));
      check("scan_last", 32'(b8.out_last), 32'(j == N-1));
      check("scan_busy", 32'(b8.busy),     32'(1));
      check("scan_in_ready", 32'(b8.in_ready), 32'(0));
      if (j == 2) begin
        b8.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_data", 32'(b8.out_data), 32'hA2);
          check("stall_ch",   32'(b8.out_ch),   32'(2));
        end
        b8.out_ready = 1'b1;
      end
      b8.mode = ~b8.mode;
      b8.sel  = 3'($urandom_range(0, 7));
      tick();
    end
    check("scan_end_busy",     32'(b8.busy),      32'(0));
    check("scan_end_valid",    32'(b8.out_valid), 32'(0));
    check("scan_end_in_ready", 32'(b8.in_ready),  32'(1));

    // Reset mid-scan after channel 3 has been handed over.
    load8(8'h30);
    b8.mode = MODE_SCAN; b8.in_valid = 1'b1; tick();
    b8.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    check("midscan_ch", 32'(b8.out_ch), 32'(4));
    rst = 1'b1; tick();
    rst = 1'b0;
    check("midrst_valid", 32'(b8.out_valid), 32'(0));
    check("midrst_busy",  32'(b8.busy),      32'(0));
    load8(8'h50);
    b8.mode = MODE_DIRECT; b8.sel = 3'd1; b8.in_valid = 1'b1; tick();
    b8.in_valid = 1'b0;
    check("midrst_new_data", 32'(b8.out_data), 32'h51);
    check("midrst_new_ch",   32'(b8.out_ch),   32'(1));
    tick();

    // N = 5: out-of-range select, in-range select, short scan.
    for (int k = 0; k < N5; k++) b5.in_data[k*W +: W] = 8'(8'h60 + 8'(k));
    b5.mode = MODE_DIRECT; b5.sel = 3'd6; b5.in_valid = 1'b1; tick();
    check("oor_data",  32'(b5.out_data),  32'(0));
    check("oor_ch",    32'(b5.out_ch),    32'(6));
    check("oor_valid", 32'(b5.out_valid), 32'(1));
    b5.sel = 3'd4; tick();
    check("n5_dir_data", 32'(b5.out_data), 32'h64);
    b5.mode = MODE_SCAN; tick();
    b5.in_valid = 1'b0;
    for (int j = 0; j < N5; j++) begin
      check("n5_scan_data", 32'(b5.out_data), 32'(8'h60 + j));
      check("n5_scan_last", 32'(b5.out_last), 32'(j == N5-1));
      tick();
    end
    check("n5_scan_done", 32'(b5.busy), 32'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      b8.in_data   = {$urandom, $urandom};
      b8.in_valid  = ($urandom_range(0, 3) != 0);
      b8.mode      = ($urandom_range(0, 3) == 0);
      b8.sel       = 3'($urandom_range(0, 7));
      b8.out_ready = ($urandom_range(0, 9) < 7);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
